// File: rtl/jump_target_skid.sv
// jump_target_skid: two-entry skid receive stage that forms J-type jump targets.
// Define JT_FLUSH_EN to compile in the flush path; otherwise flush is ignored.
module jump_target_skid #(
  parameter int IDX_W  = 26,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [ADDR_W-1:0] in_pc4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_target,
  input  logic              flush,
  output logic [15:0]       jump_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Low bits of the target come from index and the 2'b00 word offset.
  localparam logic [ADDR_W-1:0] LO_MASK =
    {ADDR_W{1'b1}} >> (ADDR_W - IDX_W - 2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] main_q, main_d;
  logic [ADDR_W-1:0] skid_q, skid_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] tgt;
  logic              acc;
  logic              dlv;

`ifndef JT_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  assign in_ready   = (state_q != TWO);
  assign out_valid  = (state_q != EMPTY);
  assign out_target = main_q;
  assign jump_cnt   = cnt_q;

  assign acc = in_valid & in_ready;
  assign dlv = out_valid & out_ready;

  assign tgt = (in_pc4 & ~LO_MASK)
             | (ADDR_W'(in_index) << 2);

  // Next state, buffer loads and delivery counter.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q + {15'd0, dlv};
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = tgt;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && dlv) begin
          main_d = tgt;
        end else if (acc) begin
          skid_d  = tgt;
          state_d = TWO;
        end else if (dlv) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (dlv) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
`ifdef JT_FLUSH_EN
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
`endif
  end

  // State, storage and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_jump_target_skid.sv
// tb_jump_target_skid: scoreboard bench for jump_target_skid.
// Reference model is a FIFO of expected targets plus a delivery count.
module tb_jump_target_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [25:0] in_index = '0;
  logic [31:0] in_pc4 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_target;
  logic [15:0] jump_cnt;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [15:0] cnt_m = '0;
  bit          en_mon = 1'b0;
  int          mon_dlv = 0;

  always #5 clk = ~clk;

  jump_target_skid #(.IDX_W(26), .ADDR_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_index(in_index),
    .in_pc4(in_pc4),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_target(out_target),
    .flush(flush),
    .jump_cnt(jump_cnt)
  );

  function automatic logic [31:0] target_of(logic [25:0] idx,
                                            logic [31:0] pc4);
    return (pc4 & 32'hF000_0000) + 32'(idx) * 32'd4;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs with the model, retires deliveries.
  always @(negedge clk) begin
    mon_dlv = 0;
    if (rst_n && en_mon) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      check("jump_cnt", 32'(jump_cnt), 32'(cnt_m));
      if (exp_q.size() > 0) begin
        check("out_target", out_target, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          mon_dlv = 1;
          cnt_m++;
        end
      end
    end
  end

  // Model input side: records accepted beats, applies flush.
  always @(negedge clk) begin
    int occ;
    bit fl;
    #1;
    if (rst_n && en_mon) begin
      occ = exp_q.size() + mon_dlv;
      fl = 1'b0;
`ifdef JT_FLUSH_EN
      fl = flush;
`endif
      if (fl)
        exp_q.delete();
      else if (in_valid && occ < 2)
        exp_q.push_back(target_of(in_index, in_pc4));
    end
  end

  task automatic drive(bit v, logic [25:0] idx, logic [31:0] pc,
                       bit r, bit f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_index  = idx;
    in_pc4    = pc;
    out_ready = r;
    flush     = f;
  endtask

  task automatic rnd(bit v, bit r, bit f);
    drive(v, 26'($urandom), $urandom, r, f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    en_mon = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_target", out_target, 32'd0);
    check("rst_jump_cnt", 32'(jump_cnt), 32'd0);
    exp_q.delete();
    cnt_m = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    en_mon = 1'b1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_in_ready", 32'(in_ready), 32'd1);
    check("init_out_target", out_target, 32'd0);
    rst_n = 1'b1;
    en_mon = 1'b1;

    // single beat with all-ones index
    drive(1, 26'h3FF_FFFF, 32'hA000_0004, 0, 0);
    drive(0, 26'd0, 32'd0, 0, 0);
    @(negedge clk);
    check("single_target", out_target, 32'hAFFF_FFFC);
    check("single_valid", 32'(out_valid), 32'd1);
    drive(0, 26'd0, 32'd0, 1, 0);
    drive(0, 26'd0, 32'd0, 1, 0);

    // stream, reset mid-stream, then 8 back-to-back beats
    repeat (4) rnd(1, 1, 0);
    do_reset();
    for (int i = 0; i < 8; i++) rnd(1, 1, 0);
    rnd(0, 1, 0);
    rnd(0, 1, 0);
    @(negedge clk);
    check("stream_cnt8", 32'(jump_cnt), 32'd8);

    // back-pressure: 3 offered, 2 taken, then 5-cycle stall in TWO
    repeat (3) rnd(1, 0, 0);
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (5) rnd(0, 0, 0);
    repeat (4) rnd(0, 1, 0);

    // flush in TWO with a beat offered
    repeat (2) rnd(1, 0, 0);
    rnd(1, 0, 1);
    rnd(0, 0, 0);
`ifdef JT_FLUSH_EN
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
`endif
    repeat (4) rnd(0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      rnd(($urandom % 4) != 0, ($urandom % 3) != 0,
          ($urandom % 40) == 0);
    repeat (4) rnd(0, 1, 0);

    // counter wrap
    do_reset();
    n = 0;
    while (cnt_m != 16'hFFFF && n < 70000) begin
      rnd(1, 1, 0);
      n++;
    end
    #1;
    check("wrap_ffff", 32'(jump_cnt), 32'h0000_FFFF);
    rnd(0, 1, 0);
    #1;
    check("wrap_zero", 32'(jump_cnt), 32'd0);
    repeat (3) rnd(0, 1, 0);

    en_mon = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
